// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared defaults and types for the instruction fetch unit
// Contents: default address/data widths, default reset PC, the FIFO entry
// type (PC paired with the instruction fetched from it) and the FSM state type.
package instr_fetch_unit_pkg;

    localparam int IFU_AW = 32;
    localparam int IFU_DW = 32;
    localparam logic [IFU_AW-1:0] IFU_RESET_PC = 32'h0;

    typedef struct packed {
        logic [IFU_AW-1:0] pc;
        logic [IFU_DW-1:0] instr;
    } fetch_entry_t;

    // RUN: every response is kept. DRAIN: responses to pre-redirect requests
    // are still in flight and must be discarded as they arrive.
    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - memory, decode and redirect channels of the fetch unit
// Signals:
//   mem_req_valid/mem_req_ready/mem_addr  read request channel to instruction memory
//   mem_rsp_valid/mem_rsp_data            in-order read responses from memory
//   ifu_valid/ifu_ready/ifu_instr/ifu_pc  instruction stream to decode
//   redirect_valid/redirect_pc            taken-branch redirect from execute
// Modports: master = fetch unit side, slave = memory/decode/execute side.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int AW = IFU_AW,
    parameter int DW = IFU_DW
);

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          ifu_valid;
    logic          ifu_ready;
    logic [DW-1:0] ifu_instr;
    logic [AW-1:0] ifu_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;

    modport master (
        output mem_req_valid, mem_addr, ifu_valid, ifu_instr, ifu_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, ifu_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_addr, ifu_valid, ifu_instr, ifu_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, ifu_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - DEPTH-entry instruction FIFO with flush and registered head
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write one entry (ignored while flushing)
//   pop              remove the head entry (ignored while empty or flushing)
//   flush            empty the FIFO this cycle
//   count            number of stored entries
//   head             registered copy of the oldest entry ('0 while empty)
module ifu_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d;
    logic [CW-1:0]   count_d;
    entry_t          head_d;
    logic            do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count != '0) && !flush;
        do_push  = push && !flush && ((count != CW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr;
        wr_ptr_d = wr_ptr;
        count_d  = count;
        head_d   = head;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr + 1'b1;
            end
            count_d = count + CW'(do_push) - CW'(do_pop);
            // The next head is either already stored, or it is the entry being
            // written this cycle (push into empty, or push+pop with one entry).
            if (count_d == '0) begin
                head_d = '0;
            end else if (do_push && (wr_ptr == rd_ptr_d)) begin
                head_d = push_data;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_ptr_d;
            wr_ptr <= wr_ptr_d;
            count  <= count_d;
            head   <= head_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, request credit, response buffering, redirect
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    instr_fetch_unit_if.master: memory request/response, decode output, redirect
// Parameters: DEPTH (FIFO entries and request credit), AW, DW, RESET_PC.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int            DEPTH    = 4,
    parameter int            AW       = IFU_AW,
    parameter int            DW       = IFU_DW,
    parameter logic [AW-1:0] RESET_PC = AW'(IFU_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_fetch_unit_if.master     bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    ifu_state_t    state, state_d;
    logic [AW-1:0] fetch_pc, fetch_pc_d;
    logic [AW-1:0] rsp_pc, rsp_pc_d;
    logic [CW-1:0] outstanding, outstanding_d;
    logic [CW-1:0] drop, drop_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic          req_fire, push, pop, flush;
    entry_t        push_data, head;

    // A request is only issued when a FIFO slot is guaranteed for its response,
    // so responses never need backpressure. Gating with rst_n keeps the request
    // low for the whole reset, not just after the first edge.
    assign in_use            = {1'b0, outstanding} + {1'b0, fifo_count};
    assign bus.mem_req_valid = rst_n && !bus.redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign bus.mem_addr      = fetch_pc;
    assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

    assign flush     = bus.redirect_valid;
    assign pop       = bus.ifu_valid && bus.ifu_ready && !bus.redirect_valid;
    assign push_data = {rsp_pc, bus.mem_rsp_data};

    always_comb begin
        state_d       = state;
        fetch_pc_d    = fetch_pc;
        rsp_pc_d      = rsp_pc;
        drop_d        = drop;
        push          = 1'b0;
        outstanding_d = outstanding + CW'(req_fire) - CW'(bus.mem_rsp_valid);
        if (bus.redirect_valid) begin
            // Everything still in flight after this cycle predates the branch.
            // A response arriving now is stale too, hence outstanding_d.
            fetch_pc_d = bus.redirect_pc;
            rsp_pc_d   = bus.redirect_pc;
            drop_d     = outstanding_d;
            state_d    = (outstanding_d != '0) ? S_DRAIN : S_RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc + 1'b1;
            end
            case (state)
                S_RUN: begin
                    if (bus.mem_rsp_valid) begin
                        push     = 1'b1;
                        rsp_pc_d = rsp_pc + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.mem_rsp_valid) begin
                        drop_d = drop - 1'b1;
                        if (drop == CW'(1)) begin
                            state_d = S_RUN;
                        end
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            rsp_pc      <= rsp_pc_d;
            outstanding <= outstanding_d;
            drop        <= drop_d;
        end
    end

    ifu_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .count     (fifo_count),
        .head      (head)
    );

    assign bus.ifu_valid = (fifo_count != '0);
    assign bus.ifu_instr = head.instr;
    assign bus.ifu_pc    = head.pc;

    a_counters_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        (outstanding <= CW'(DEPTH)) && (fifo_count <= CW'(DEPTH)) &&
        (drop <= outstanding) && (in_use <= (CW+1)'(DEPTH)));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the decode/execute processor. Owns the fetch PC and issues word-addressed read requests to instruction memory over a valid/ready request channel with in-order responses. Buffers returned instructions with their PCs in a small FIFO feeding decode via valid/ready. Accepts an absolute redirect for taken branches: flushes the buffer and discards stale in-flight responses.

Parameters:
DEPTH, 4, instruction FIFO entries and max outstanding+buffered requests (power of 2, >=2)
RESET_PC, 32'h0, fetch PC after reset
AW, 32, address/PC width (word address)
DW, 32, instruction width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  AW  request word address (= fetch PC)
mem_rsp_valid  in  1  read data valid, strictly in request order, >=1 cycle after acceptance
mem_rsp_data  in  DW  read data
ifu_valid  out  1  instruction available to decode
ifu_ready  in  1  decode consumes instruction
ifu_instr  out  DW  head instruction
ifu_pc  out  AW  PC of head instruction
redirect_valid  in  1  taken branch, one-cycle pulse
redirect_pc  in  AW  absolute branch target

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, state=RUN; outputs mem_req_valid=0, mem_addr=RESET_PC, ifu_valid=0, ifu_instr=0, ifu_pc=0.
- Credit: mem_req_valid=1 iff !redirect_valid && (outstanding + fifo_count) < DEPTH; guarantees every response has a FIFO slot. mem_addr=fetch_pc (registered). mem_req_valid may deassert only after acceptance or on redirect.
- Request accept (valid&&ready): fetch_pc+=1 (wraps modulo 2^AW), outstanding+=1.
- Response: outstanding-=1. If drop>0: discard, drop-=1. Else push {rsp_pc, mem_rsp_data}, rsp_pc+=1.
- Decode side: ifu_valid = FIFO non-empty; head registered; pop on ifu_valid&&ifu_ready. Latency: response at edge t is visible on ifu_* after edge t (earliest consume cycle t+1); no bypass.
- Push and pop same cycle: both take effect, count unchanged (legal when full).
- States: RUN (drop==0), DRAIN (drop>0). RUN->DRAIN on redirect with outstanding-after-this-cycle>0; DRAIN->RUN when last stale response discarded. Requests to the new target may issue in DRAIN; their responses follow the stale ones and are kept.
- Redirect (highest priority): FIFO flushed, pop ignored, any request that cycle suppressed (mem_req_valid=0), fetch_pc=rsp_pc=redirect_pc, drop = outstanding minus a response arriving that cycle (that response also discarded). ifu_valid=0 next cycle. Redirect during DRAIN: drop = all outstanding.
- Counters: outstanding, drop, fifo_count are clog2(DEPTH)+1 bits; never exceed DEPTH (assertion).
- Reset mid-operation: all state cleared immediately; responses for pre-reset requests are memory's responsibility (memory is reset together).

Decomposition:
- Shared package: AW/DW defaults, RESET_PC default, fetch_entry_t struct {pc, instr}.
- One sub-module: ifu_fifo (synchronous DEPTH-entry FIFO, push/pop/flush, count, registered head).
- Top holds PC, counters, RUN/DRAIN FSM, credit logic.

Test Plan:
- Reset: rst_n low mid-cycle -> mem_req_valid=0, ifu_valid=0 asynchronously; after release first mem_addr=0x0, then 0x1, 0x2.
- Streaming, 1-cycle memory, ifu_ready=1: ifu_pc sequence 0,1,2,3 one per cycle after initial latency, ifu_instr equals memory word at each PC.
- Backpressure: ifu_ready=0 -> exactly 4 requests accepted (addr 0..3), mem_req_valid then 0; one pop -> exactly one new request, addr 0x4.
- Redirect with 2 outstanding (3-cycle memory): redirect_pc=0x40 -> state DRAIN, 2 responses discarded, first ifu_pc=0x40, next 0x41; no instruction from 0x2/0x3 appears.
- Simultaneous redirect + pop + response: FIFO empty next cycle, the arriving response discarded, fetch resumes at redirect_pc the following cycle.
- Memory stall: mem_req_ready=0 for 5 cycles -> mem_addr held constant, fetch_pc not incremented, no duplicate instruction delivered.
